// File: rtl/traffic_phase_arbiter_if.sv
// Light/call bus between the intersection arbiter and the board lamp/button logic.
// master: drives call buttons, observes lamps. slave: the arbiter.
interface traffic_phase_arbiter_if;
  logic       req_ns;
  logic       req_ew;
  logic       req_ped;
  logic [5:0] light_out;  // {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r}
  logic       walk;
  logic [2:0] pending;    // {ped, ew, ns}

  modport master (output req_ns, req_ew, req_ped, input light_out, walk, pending);
  modport slave  (input req_ns, req_ew, req_ped, output light_out, walk, pending);
endinterface

// File: rtl/traffic_phase_arbiter.sv
// Request-driven phase scheduler for a two-road intersection.
// Latches NS/EW/pedestrian calls, grants them round-robin and sequences
// green, yellow, all-red and walk intervals on a tick prescaler.
// Optional pedestrian phase: define PED_PHASE_EN to enable it.
module traffic_phase_arbiter #(
  parameter int unsigned TICK_DIV  = 50000000,
  parameter int unsigned GREEN_MIN = 8,
  parameter int unsigned YELLOW_T  = 3,
  parameter int unsigned ALLRED_T  = 2,
  parameter int unsigned PED_T     = 5
) (
  input logic                    clock,
  input logic                    reset,
  traffic_phase_arbiter_if.slave bus
);

  localparam int unsigned    PW         = $clog2(TICK_DIV);
  localparam logic [PW-1:0]  PRESC_MAX  = PW'(TICK_DIV - 1);
  localparam logic [7:0]     GREEN_MIN8 = 8'(GREEN_MIN);
  localparam logic [7:0]     YELLOW_T8  = 8'(YELLOW_T);
  localparam logic [7:0]     ALLRED_T8  = 8'(ALLRED_T);
  localparam logic [7:0]     PED_T8     = 8'(PED_T);

  localparam logic [5:0] L_NS_G    = 6'b100001;
  localparam logic [5:0] L_NS_Y    = 6'b010001;
  localparam logic [5:0] L_EW_G    = 6'b001100;
  localparam logic [5:0] L_EW_Y    = 6'b001010;
  localparam logic [5:0] L_ALL_RED = 6'b001001;

  typedef enum logic [2:0] {
    NS_G,
    NS_Y,
    EW_G,
    EW_Y,
`ifdef PED_PHASE_EN
    PED_WALK,
`endif
    ALL_RED
  } state_t;

  typedef enum logic [1:0] {PH_NS, PH_EW, PH_PED} phase_t;

  logic [2:0]    req_raw;
  logic [2:0]    sync1_q, sync1_d;
  logic [2:0]    sync2_q, sync2_d;
  logic [2:0]    pending_q, pending_d;
  state_t        state_q, state_d;
  phase_t        last_q, last_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    timer_q, timer_d;
  logic [5:0]    light_q, light_d;
  logic          walk_q, walk_d;
  logic          tick;
  logic [7:0]    elapsed;

`ifdef PED_PHASE_EN
  assign req_raw = {bus.req_ped, bus.req_ew, bus.req_ns};
`else
  logic unused_req_ped;
  assign unused_req_ped = bus.req_ped;
  assign req_raw = {1'b0, bus.req_ew, bus.req_ns};
`endif

  // Round-robin pick starting after the last granted phase; NS_G when idle.
  function automatic state_t pick_next(input logic [2:0] p, input phase_t last);
    state_t s;
    s = NS_G;
    case (last)
      PH_NS: begin
        if (p[1]) s = EW_G;
`ifdef PED_PHASE_EN
        else if (p[2]) s = PED_WALK;
`endif
      end
      PH_EW: begin
`ifdef PED_PHASE_EN
        if (p[2]) s = PED_WALK;
        else
`endif
        if (!p[0] && p[1]) s = EW_G;
      end
`ifdef PED_PHASE_EN
      PH_PED: begin
        if (!p[0] && p[1]) s = EW_G;
        else if (!p[0] && !p[1] && p[2]) s = PED_WALK;
      end
`endif
      default: s = NS_G;
    endcase
    return s;
  endfunction

  // Next-state, call latching, interval timing and lamp decode.
  always_comb begin
    sync1_d   = req_raw;
    sync2_d   = sync1_q;
    pending_d = pending_q | sync2_q;
    state_d   = state_q;
    last_d    = last_q;
    tick      = (presc_q == PRESC_MAX);
    elapsed   = (timer_q == 8'hFF) ? timer_q : timer_q + 8'd1;

    case (state_q)
      NS_G: if (tick && elapsed >= GREEN_MIN8 && (pending_q[1] || pending_q[2])) state_d = NS_Y;
      NS_Y: if (tick && elapsed >= YELLOW_T8) state_d = ALL_RED;
      EW_G: if (tick && elapsed >= GREEN_MIN8 && (pending_q[0] || pending_q[2])) state_d = EW_Y;
      EW_Y: if (tick && elapsed >= YELLOW_T8) state_d = ALL_RED;
`ifdef PED_PHASE_EN
      PED_WALK: if (tick && elapsed >= PED_T8) state_d = ALL_RED;
`endif
      ALL_RED: if (tick && elapsed >= ALLRED_T8) state_d = pick_next(pending_q, last_q);
      default: state_d = NS_G;
    endcase

    // A state change restarts the prescaler and timer; entering a green/walk
    // state is the grant, which also swallows a same-cycle synchronized call.
    if (state_d != state_q) begin
      presc_d = '0;
      timer_d = '0;
      case (state_d)
        NS_G: begin
          pending_d[0] = 1'b0;
          last_d       = PH_NS;
        end
        EW_G: begin
          pending_d[1] = 1'b0;
          last_d       = PH_EW;
        end
`ifdef PED_PHASE_EN
        PED_WALK: begin
          pending_d[2] = 1'b0;
          last_d       = PH_PED;
        end
`endif
        default: ;
      endcase
    end else begin
      presc_d = tick ? '0 : presc_q + PW'(1);
      timer_d = tick ? elapsed : timer_q;
    end

    light_d = L_ALL_RED;
    walk_d  = 1'b0;
    case (state_d)
      NS_G: light_d = L_NS_G;
      NS_Y: light_d = L_NS_Y;
      EW_G: light_d = L_EW_G;
      EW_Y: light_d = L_EW_Y;
`ifdef PED_PHASE_EN
      PED_WALK: walk_d = 1'b1;
`endif
      default: light_d = L_ALL_RED;
    endcase
  end

  // State and registered outputs; reset acts immediately.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      pending_q <= '0;
      state_q   <= NS_G;
      last_q    <= PH_NS;
      presc_q   <= '0;
      timer_q   <= '0;
      light_q   <= L_NS_G;
      walk_q    <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      pending_q <= pending_d;
      state_q   <= state_d;
      last_q    <= last_d;
      presc_q   <= presc_d;
      timer_q   <= timer_d;
      light_q   <= light_d;
      walk_q    <= walk_d;
    end
  end

  assign bus.light_out = light_q;
  assign bus.walk      = walk_q;
  assign bus.pending   = pending_q;

endmodule

// File: tb/tb_traffic_phase_arbiter.sv
// Bench for traffic_phase_arbiter with TICK_DIV=4, GREEN_MIN=2, YELLOW_T=3,
// ALLRED_T=1, PED_T=5. Cycle n below = sampled 1 time unit after the n-th
// rising edge following reset release.
`timescale 1ns/1ps
module tb_traffic_phase_arbiter;

  localparam logic [5:0] L_NSG = 6'b100001;
  localparam logic [5:0] L_NSY = 6'b010001;
  localparam logic [5:0] L_EWG = 6'b001100;
  localparam logic [5:0] L_EWY = 6'b001010;
  localparam logic [5:0] L_AR  = 6'b001001;

  logic clock = 1'b0;
  logic reset = 1'b0;

  traffic_phase_arbiter_if bus ();

  traffic_phase_arbiter #(
    .TICK_DIV (4),
    .GREEN_MIN(2),
    .YELLOW_T (3),
    .ALLRED_T (1),
    .PED_T    (5)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [5:0] light;
    logic       walk;
    logic [2:0] pend;
    string      name;
  } exp_t;

  typedef struct {
    logic        ns;
    logic        ew;
    logic        ped;
    int unsigned n;
    exp_t        e;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: actual=%b required=%b", nm, $time, act, req);
    end
  endtask

  task automatic check_outputs(input exp_t e);
    cmp({e.name, ".light"}, {2'b00, bus.light_out}, {2'b00, e.light});
    cmp({e.name, ".walk"}, {7'd0, bus.walk}, {7'd0, e.walk});
    cmp({e.name, ".pending"}, {5'd0, bus.pending}, {5'd0, e.pend});
  endtask

  task automatic sample_out();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_underflow at %0t: actual=empty required=entry", $time);
    end else begin
      e = sb.pop_front();
      check_outputs(e);
    end
  endtask

  task automatic step(input logic ns, input logic ew, input logic ped, input exp_t e);
    bus.req_ns  = ns;
    bus.req_ew  = ew;
    bus.req_ped = ped;
    sb.push_back(e);
    @(posedge clock);
    #1;
    sample_out();
  endtask

  function automatic void add(input logic ns, input logic ew, input logic ped, input int unsigned n,
                              input logic [5:0] l, input logic w, input logic [2:0] p, input string nm);
    vec_t v;
    v.ns = ns; v.ew = ew; v.ped = ped; v.n = n;
    v.e.light = l; v.e.walk = w; v.e.pend = p; v.e.name = nm;
    tbl.push_back(v);
  endfunction

  task automatic run_table();
    foreach (tbl[i]) begin
      for (int unsigned k = 0; k < tbl[i].n; k++) step(tbl[i].ns, tbl[i].ew, tbl[i].ped, tbl[i].e);
    end
    tbl.delete();
  endtask

  // Assert reset away from the edge, check async reset values, release away from the edge.
  task automatic apply_reset(input string nm);
    exp_t r;
    r = '{L_NSG, 1'b0, 3'b000, nm};
    bus.req_ns = 1'b0; bus.req_ew = 1'b0; bus.req_ped = 1'b0;
    reset = 1'b0;
    #1;
    check_outputs(r);
    @(posedge clock);
    #1;
    check_outputs(r);
    sb.delete();
    reset = 1'b1;
  endtask

  // EW call from reset: pending at cycle 3, NS_Y 8..19, ALL_RED 20..23.
  function automatic void add_ew_prefix();
    add(0, 1, 0, 1,  L_NSG, 0, 3'b000, "a_req_ew");
    add(0, 0, 0, 1,  L_NSG, 0, 3'b000, "a_sync");
    add(0, 0, 0, 5,  L_NSG, 0, 3'b010, "a_ew_pending");
    add(0, 0, 0, 12, L_NSY, 0, 3'b010, "a_ns_yellow");
    add(0, 0, 0, 4,  L_AR,  0, 3'b010, "a_all_red");
  endfunction

  initial begin
    exp_t e_async;
    bus.req_ns = 1'b0; bus.req_ew = 1'b0; bus.req_ped = 1'b0;
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_outputs('{L_NSG, 1'b0, 3'b000, "reset_state"});
    reset = 1'b1;

`ifdef PED_PHASE_EN
    for (int i = 0; i < 200; i++) step(0, 0, 0, '{L_NSG, 1'b0, 3'b000, "idle"});
    apply_reset("reset_before_ped");

    add_ew_prefix();
    // EW green from 24; ped call driven 33..35 reaches pending at the cycle-35 tick.
    add(0, 0, 0, 9,  L_EWG, 0, 3'b000, "b_ew_green");
    add(0, 0, 1, 2,  L_EWG, 0, 3'b000, "b_req_ped");
    add(0, 0, 1, 1,  L_EWG, 0, 3'b100, "b_ped_pending");
    add(0, 0, 0, 12, L_EWY, 0, 3'b100, "b_ew_yellow");
    add(0, 0, 0, 4,  L_AR,  0, 3'b100, "b_all_red");
    add(0, 0, 0, 20, L_AR,  1, 3'b000, "b_walk");
    add(0, 0, 0, 4,  L_AR,  0, 3'b000, "b_all_red2");
    // Back to NS green at 76, EW served again, then NS+PED both waiting: PED first.
    add(0, 0, 0, 1,  L_NSG, 0, 3'b000, "c_ns_green");
    add(0, 1, 0, 1,  L_NSG, 0, 3'b000, "c_req_ew");
    add(0, 0, 0, 1,  L_NSG, 0, 3'b000, "c_sync");
    add(0, 0, 0, 5,  L_NSG, 0, 3'b010, "c_ew_pending");
    add(0, 0, 0, 12, L_NSY, 0, 3'b010, "c_ns_yellow");
    add(0, 0, 0, 4,  L_AR,  0, 3'b010, "c_all_red");
    add(0, 0, 0, 1,  L_EWG, 0, 3'b000, "c_ew_green");
    add(1, 0, 1, 1,  L_EWG, 0, 3'b000, "c_req_ns_ped");
    add(0, 0, 0, 1,  L_EWG, 0, 3'b000, "c_sync2");
    add(0, 0, 0, 5,  L_EWG, 0, 3'b101, "c_both_pending");
    add(0, 0, 0, 12, L_EWY, 0, 3'b101, "c_ew_yellow");
    add(0, 0, 0, 4,  L_AR,  0, 3'b101, "c_all_red2");
    add(0, 0, 0, 20, L_AR,  1, 3'b001, "c_ped_first");
    add(0, 0, 0, 4,  L_AR,  0, 3'b001, "c_all_red3");
    add(0, 0, 0, 3,  L_NSG, 0, 3'b000, "c_ns_after");
    run_table();
    apply_reset("reset_before_ewy");
`else
    for (int i = 0; i < 500; i++) step(0, 0, i[0], '{L_NSG, 1'b0, 3'b000, "ped_ignored"});
    apply_reset("reset_after_ped_toggle");
`endif

    add_ew_prefix();
    // EW green from 24; NS call at 25 pends at 27, exit at the cycle-31 tick.
    add(0, 0, 0, 1, L_EWG, 0, 3'b000, "d_ew_green");
    add(1, 0, 0, 1, L_EWG, 0, 3'b000, "d_req_ns");
    add(0, 0, 0, 1, L_EWG, 0, 3'b000, "d_sync");
    add(0, 0, 0, 5, L_EWG, 0, 3'b001, "d_ns_pending");
    add(0, 0, 0, 6, L_EWY, 0, 3'b001, "d_ew_yellow");
    run_table();

    // Reset in the middle of EW yellow, observed before the next clock edge.
    #2;
    reset = 1'b0;
    #1;
    e_async = '{L_NSG, 1'b0, 3'b000, "async_reset_mid_ewy"};
    check_outputs(e_async);
    @(posedge clock);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) step(0, 0, 0, '{L_NSG, 1'b0, 3'b000, "after_reset"});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/traffic_phase_arbiter.md
# traffic_phase_arbiter

Request-driven phase scheduler for a single two-road intersection with an optional pedestrian phase. Latches NS, EW and pedestrian call buttons, arbitrates between them round-robin, and sequences green, yellow, all-red and walk intervals using a tick prescaler. It drives the six-lamp light bus consumed by the board LED/lamp outputs, replacing hard-coded per-state counters with parameterised timing.

## Interface
- TICK_DIV, 50000000: clock cycles per timing tick (2..2^26).
- GREEN_MIN, 8: minimum green duration in ticks (1..255).
- YELLOW_T, 3: yellow duration in ticks (1..255).
- ALLRED_T, 2: all-red clearance duration in ticks (1..255).
- PED_T, 5: walk duration in ticks (1..255).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low.
- req_ns  in  1  NS call, asynchronous level (button).
- req_ew  in  1  EW call, asynchronous level.
- req_ped  in  1  pedestrian call, asynchronous level.
- light_out  out  6  {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r}.
- walk  out  1  pedestrian walk lamp.
- pending  out  3  latched calls {ped, ew, ns}.

## Operation
- Each req_* passes through a 2-flop synchronizer; a synchronized high sets its pending bit, which holds until that phase is granted.
- States and light_out: NS_G 100001, NS_Y 010001, EW_G 001100, EW_Y 001010, ALL_RED 001001, PED_WALK 001001 with walk=1. walk=0 in all other states.
- Grant = entry into NS_G, EW_G or PED_WALK; it clears that phase's pending bit. A synchronized request high in the grant cycle is absorbed, leaving the bit 0.
- NS_G/EW_G: exit to own yellow at the first tick boundary where elapsed ≥ GREEN_MIN and any other pending bit is set; otherwise hold indefinitely.
- NS_Y/EW_Y → ALL_RED after YELLOW_T ticks. PED_WALK → ALL_RED after PED_T ticks.
- ALL_RED lasts ALLRED_T ticks, then arbitrates. It scans the pending bits round-robin, starting after the last granted phase, in the order NS → EW → PED → NS. The first set bit wins. If none are set, go to NS_G.
- A pending bit for the phase just served may be re-granted only if no other bit is set.

## Timing
- Prescaler counts 0..TICK_DIV-1 and emits a tick when it reaches TICK_DIV-1.
- Prescaler and phase timer both clear on every state change, so a state of duration D lasts exactly D*TICK_DIV cycles.
- Request-to-pending latency is 2 cycles, plus 1 cycle for the pending register.
- Green exit decision and state change occur on the tick cycle; light_out updates on the next edge (registered output).
- Reset values, applied immediately on reset low at any time:
  - state NS_G, light_out 100001, walk 0, pending 000;
  - prescaler 0, timer 0, last-granted NS.
- Phase timer is 8 bits and never wraps; a green hold saturates at 255.

## Configuration
- PED_PHASE_EN defined: pedestrian path active as described.
- PED_PHASE_EN undefined: req_ped ignored, pending[2] and walk tied 0, PED_WALK state absent, arbitration is NS/EW alternation only. Ports remain present.

## Test plan
Common bench parameters: TICK_DIV=4, GREEN_MIN=2, YELLOW_T=3, ALLRED_T=1, PED_T=5.
- Reset, no requests, 200 cycles → light_out stays 100001, walk 0, pending 000.
- req_ew pulsed 1 cycle at cycle 0 after reset release:
  - pending = 010 at cycle 3;
  - NS_Y (010001) from cycle 8 for 12 cycles, ALL_RED for 4 cycles;
  - EW_G 001100 at cycle 24 with pending 000.
- req_ped held in EW_G after min green → EW_Y → ALL_RED → PED_WALK 20 cycles with walk=1 → ALL_RED → NS_G (nothing pending).
- req_ns and req_ped both pending while ALL_RED follows EW service → PED granted first (round-robin after EW), NS afterward.
- reset asserted mid-EW_Y → light_out 100001 and pending 000 asynchronously, before the next clock edge.
- With PED_PHASE_EN undefined: req_ped toggled for 500 cycles → light_out never leaves 100001 and walk stays 0.
